// File: rtl/aes_iter_core.sv
// -----------------------------------------------------------------------------
// aes_iter_core
//
// Iterative FIPS-197 AES encryption core. One round is computed per clock on a
// single round datapath, and the round keys are expanded on the fly from the
// key registers, so no key schedule is stored.
//
// Parameters
//   DATA_W   block width in bits (128 only)
//   KEY_LEN  cipher key length, 128 (NR = 10) or 256 (NR = 14)
//
// Build option
//   AES_KEY_REUSE_EN  when defined, the last key loaded with key_valid_in = 1
//                     is kept, and a block accepted with key_valid_in = 0 is
//                     encrypted with that stored key. When undefined there is
//                     no key store and cipher_key is always used.
//
// Ports
//   clk           clock, rising edge
//   reset         asynchronous, active-high reset
//   in_valid      plaintext block (and key) offered
//   in_ready      core accepts a block this cycle (IDLE and not in reset)
//   key_valid_in  load cipher_key with this block (sampled on accept only)
//   cipher_key    cipher key, MSB = first key byte
//   plain_text    plaintext, MSB = first state byte
//   out_valid     cipher_text holds a finished block
//   out_ready     downstream takes the block
//   cipher_text   ciphertext
//   busy          high while rounds are being computed
//   dbg_state     current FSM state (IDLE=0, ROUND=1, DONE=2)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its data stable until that edge; the
// core never retracts out_valid or changes cipher_text before the transfer,
// and in_ready does not depend on in_valid.
// -----------------------------------------------------------------------------
module aes_iter_core #(
  parameter int DATA_W  = 128,
  parameter int KEY_LEN = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               key_valid_in,
  input  logic [KEY_LEN-1:0] cipher_key,
  input  logic [DATA_W-1:0]  plain_text,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  cipher_text,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  // ---------------------------------------------------------------------------
  // Parameter legality
  // ---------------------------------------------------------------------------
  if (DATA_W != 128) begin : g_bad_data_w
    $error("aes_iter_core: DATA_W must be 128");
  end
  if (KEY_LEN != 128 && KEY_LEN != 256) begin : g_bad_key_len
    $error("aes_iter_core: KEY_LEN must be 128 or 256");
  end

  localparam int         NR   = (KEY_LEN == 256) ? 14 : 10;
  localparam logic [3:0] NR_L = 4'(NR);

  // S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // ---------------------------------------------------------------------------
  // Byte / word helpers
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] idx;
    // (255 - x) * 8 addresses entry x counted from the MSB end.
    idx = {~x, 3'b000};
    return SBOX[idx +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte n of the state sits at bits [127-8n -: 8]; byte 4c+r is row r of
  // column c. Row r is rotated left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    return {s[127:120], s[87:80],   s[47:40],   s[7:0],
            s[95:88],   s[55:48],   s[15:8],    s[103:96],
            s[63:56],   s[23:16],   s[111:104], s[71:64],
            s[31:24],   s[119:112], s[79:72],   s[39:32]};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {r0, r1, r2, r3};
  endfunction

  // One 128-bit step of the key expansion. prev holds the four words that lie
  // Nk words back; last_w is the word just before the new group. rot selects
  // RotWord+SubWord+Rcon, otherwise SubWord only (the extra Nk = 8 step).
  function automatic logic [127:0] key_step(input logic [127:0] prev,
                                            input logic [31:0]  last_w,
                                            input logic [7:0]   rcon,
                                            input logic         rot);
    logic [31:0] t, n0, n1, n2, n3;
    if (rot) t = sub_word({last_w[23:0], last_w[31:24]}) ^ {rcon, 24'h0};
    else     t = sub_word(last_w);
    n0 = prev[127:96] ^ t;
    n1 = prev[95:64]  ^ n0;
    n2 = prev[63:32]  ^ n1;
    n3 = prev[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic         accept;      // block taken on this edge
  logic         round_step;  // one round computed on this edge
  logic         last_round;  // the round being computed is round NR
  logic [3:0]   rnd_q;       // round currently being computed
  logic [7:0]   rcon_q;
  logic         rcon_adv;
  logic [127:0] st_q;
  logic [127:0] ct_q;
  logic [127:0] round_key;   // key added at the end of the current round
  logic [127:0] rk0;         // key added before round 1
  logic [KEY_LEN-1:0] key_sel;

  assign last_round = (rnd_q == NR_L);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    round_step = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !reset;
        if (in_valid && !reset) begin
          accept  = 1'b1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        busy       = 1'b1;
        round_step = 1'b1;
        if (last_round) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dbg_state   = state_q;
  assign cipher_text = ct_q;

  // ---------------------------------------------------------------------------
  // Key source for the accepted block
  // ---------------------------------------------------------------------------
`ifdef AES_KEY_REUSE_EN
  logic [KEY_LEN-1:0] key_store_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       key_store_q <= '0;
    else if (accept && key_valid_in) key_store_q <= cipher_key;
  end

  assign key_sel = key_valid_in ? cipher_key : key_store_q;
`else
  logic unused_key_valid_in;
  assign unused_key_valid_in = key_valid_in;
  assign key_sel = cipher_key;
`endif

  // The first 128 key bits are round key 0 for both key lengths.
  assign rk0 = key_sel[KEY_LEN-1 -: 128];

  // ---------------------------------------------------------------------------
  // On-the-fly key expansion
  // ---------------------------------------------------------------------------
  if (KEY_LEN == 256) begin : g_key256
    // ka holds round key r-1 and kb round key r while round r is computed,
    // so kb is added directly and the pair slides forward by one key.
    logic [127:0] ka_q, kb_q, k_next;

    // Round key r+1 uses RotWord/Rcon when r+1 is even, i.e. r is odd.
    assign k_next    = key_step(ka_q, kb_q[31:0], rcon_q, rnd_q[0]);
    assign round_key = kb_q;
    assign rcon_adv  = rnd_q[0];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ka_q <= '0;
        kb_q <= '0;
      end else if (accept) begin
        ka_q <= key_sel[255:128];
        kb_q <= key_sel[127:0];
      end else if (round_step) begin
        ka_q <= kb_q;
        kb_q <= k_next;
      end
    end
  end else begin : g_key128
    // k holds round key r-1; round key r is expanded combinationally and
    // added in the same cycle.
    logic [127:0] k_q, k_next;

    assign k_next    = key_step(k_q, k_q[31:0], rcon_q, 1'b1);
    assign round_key = k_next;
    assign rcon_adv  = 1'b1;

    always_ff @(posedge clk or posedge reset) begin
      if (reset)           k_q <= '0;
      else if (accept)     k_q <= key_sel[127:0];
      else if (round_step) k_q <= k_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Round datapath
  // ---------------------------------------------------------------------------
  logic [127:0] sb, sr, mc, round_out;

  for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
    assign sb[8*i +: 8] = sbox(st_q[8*i +: 8]);
  end

  assign sr = shift_rows(sb);

  for (genvar c = 0; c < 4; c++) begin : g_mix_cols
    assign mc[32*c +: 32] = mix_col(sr[32*c +: 32]);
  end

  // The final round skips MixColumns.
  assign round_out = (last_round ? sr : mc) ^ round_key;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= '0;
      ct_q   <= '0;
      rnd_q  <= '0;
      rcon_q <= '0;
    end else if (accept) begin
      st_q   <= plain_text ^ rk0;
      rnd_q  <= 4'd1;
      rcon_q <= 8'h01;
    end else if (round_step) begin
      st_q <= round_out;
      if (rcon_adv) rcon_q <= xtime(rcon_q);
      if (last_round) begin
        ct_q  <= round_out;
        rnd_q <= '0;
      end else begin
        rnd_q <= rnd_q + 4'd1;
      end
    end
  end

endmodule
